cnt_arb: RTL

Round-robin arbiter and sequencer sharing a single up-counter among N_REQ requesters. Each requester asks for a timed interval of programmable length. The block grants the counter to one requester at a time, counts the interval, and returns a one-cycle completion pulse to that requester. It sits between the block-level control FSMs and the shared timing counter, so a single counter can serve several consumers.

---
 rtl/cnt_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cnt_arb.sv
// cnt_arb: round-robin arbiter that lends one shared up-counter to N_REQ
// requesters. Each grant counts an interval of the requester's programmed
// length and ends with a one-cycle completion pulse to that requester.
module cnt_arb #(
  parameter int N_REQ = 4,
  parameter int CNTW  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*CNTW-1:0]   i_len,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_done,
  output logic [CNTW-1:0]         o_cnt,
  output logic                    o_busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  // r_ptr holds the most recent grant; during RUN it also identifies the owner
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
  logic [CNTW-1:0]  r_len, w_len_nxt;

  logic             w_any;
  logic [PW-1:0]    w_pick;
  logic [N_REQ-1:0] w_pick_oh;
  logic [CNTW-1:0]  w_pick_len;
  logic             w_owner_req;
  int               w_dist;
  int               w_best;

  // Round-robin pick: nearest active request strictly after r_ptr (wrapping)
  always_comb begin
    w_any      = 1'b0;
    w_pick     = '0;
    w_pick_oh  = '0;
    w_pick_len = '0;
    w_dist     = 0;
    w_best     = N_REQ;
    for (int j = 0; j < N_REQ; j++) begin
      // distance 0 is ptr+1, distance N_REQ-1 is ptr itself (lowest priority)
      w_dist = (j + N_REQ - 1 - int'(r_ptr)) % N_REQ;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best       = w_dist;
        w_any        = 1'b1;
        w_pick       = PW'(j);
        w_pick_oh    = '0;
        w_pick_oh[j] = 1'b1;
        w_pick_len   = i_len[j*CNTW +: CNTW];
      end
    end
  end

  // The owner still wants the counter as long as its request bit stays high
  assign w_owner_req = |(i_req & r_gnt);

  // Next-state and next-output logic of the grant/count/complete sequence
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = '0;
        w_cnt_nxt = '0;
        if (w_any) begin
          w_state_nxt = S_RUN;
          w_gnt_nxt   = w_pick_oh;
          w_len_nxt   = w_pick_len;
          w_ptr_nxt   = w_pick;
        end
      end
      S_RUN: begin
        if (!w_owner_req) begin
          // abort: release without a completion pulse, pointer keeps owner
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == r_len) begin
          // terminal compare before increment, so the counter never wraps
          w_state_nxt = S_DONE;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
          w_done_nxt  = r_gnt;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(N_REQ - 1);
      r_gnt   <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Captured interval length; only meaningful while RUN, so no reset needed
  always_ff @(posedge i_clk) begin
    r_len <= w_len_nxt;
  end

  assign o_gnt  = r_gnt;
  assign o_done = r_done;
  assign o_cnt  = r_cnt;
  assign o_busy = (r_state != S_IDLE);

endmodule
